// File: rtl/mem_ctl_arb.sv
// Round-robin arbiter that grants N_CH requesters exclusive use of one memory port.
// A timeout counter bounds each access, and every output is decoded from registered state.
`timescale 1ns/1ps

module mem_ctl_arb #(
    parameter int N_CH    = 2,
    parameter int TIMEOUT = 15,
    parameter int ID_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] din_valid,
    input  logic [N_CH-1:0] wen,
    input  logic [N_CH-1:0] dout_ack,
    input  logic            mem_done,
    output logic [N_CH-1:0] din_ack,
    output logic [N_CH-1:0] dout_valid,
    output logic            mem_write,
    output logic            mem_read,
    output logic [ID_W-1:0] grant_id,
    output logic            busy,
    output logic            mem_err
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, RESP, DACK} state_t;

    localparam logic [7:0]      TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [ID_W-1:0] LAST_CH  = ID_W'(N_CH - 1);
    localparam logic [N_CH-1:0] ONE      = N_CH'(1);

    state_t          state, state_nxt;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] cand;
    logic            found;
    logic [7:0]      tmo_cnt;
    logic            tmo_hit;
    logic            err_nxt;

    // Search starts one past the last winner, so the most recently served channel ranks last.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            cand = ID_W'((int'(last_grant) + i) % N_CH);
            if (!found && din_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign tmo_hit = (tmo_cnt == TMO_LAST);

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        case (state)
            IDLE:  if (found) state_nxt = wen[winner] ? WRITE : READ;
            // mem_done takes priority over the terminal count in the same cycle.
            WRITE: if (mem_done) state_nxt = DACK;
                   else if (tmo_hit) begin
                       state_nxt = DACK;
                       err_nxt   = 1'b1;
                   end
            READ:  if (mem_done) state_nxt = RESP;
                   else if (tmo_hit) begin
                       state_nxt = DACK;
                       err_nxt   = 1'b1;
                   end
            RESP:  if (dout_ack[grant_id]) state_nxt = DACK;
            DACK:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
        if (rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= LAST_CH;
            tmo_cnt    <= '0;
            mem_err    <= 1'b0;
        end else begin
            state   <= state_nxt;
            mem_err <= err_nxt;
            if (state == IDLE) begin
                tmo_cnt <= '0;
                if (found) begin
                    grant_id   <= winner;
                    last_grant <= winner;
                end
            end else if (state == WRITE || state == READ) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
        end
    end

    assign mem_write  = (state == WRITE);
    assign mem_read   = (state == READ);
    assign busy       = (state != IDLE);
    assign din_ack    = (state == DACK) ? (ONE << grant_id) : '0;
    assign dout_valid = (state == RESP) ? (ONE << grant_id) : '0;

endmodule

// File: tb/tb_mem_ctl_arb.sv
// Bench for mem_ctl_arb: directed scenarios on a 2-channel instance with a scoreboard,
// plus a randomised sweep on a 4-channel instance with TIMEOUT=7.
`timescale 1ns/1ps

module tb_mem_ctl_arb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 2-channel instance, TIMEOUT=15
    logic [1:0] dv, wen, dack, din_ack, dout_valid;
    logic       done, mem_write, mem_read, busy, mem_err;
    logic [0:0] grant_id;

    mem_ctl_arb #(.N_CH(2), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .din_valid(dv), .wen(wen), .dout_ack(dack),
        .mem_done(done), .din_ack(din_ack), .dout_valid(dout_valid),
        .mem_write(mem_write), .mem_read(mem_read), .grant_id(grant_id),
        .busy(busy), .mem_err(mem_err)
    );

    // 4-channel instance, TIMEOUT=7
    logic [3:0] dv4, wen4, dack4, din_ack4, dout_valid4;
    logic       done4, mem_write4, mem_read4, busy4, mem_err4;
    logic [1:0] grant_id4;

    mem_ctl_arb #(.N_CH(4), .TIMEOUT(7)) dut4 (
        .clk(clk), .rst(rst), .din_valid(dv4), .wen(wen4), .dout_ack(dack4),
        .mem_done(done4), .din_ack(din_ack4), .dout_valid(dout_valid4),
        .mem_write(mem_write4), .mem_read(mem_read4), .grant_id(grant_id4),
        .busy(busy4), .mem_err(mem_err4)
    );

    typedef struct { int ch; bit err; } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int n, k;
    bit rd_seen;
    bit sweep_on = 0;
    bit [3:0] pend = '0;
    int issued[4];
    int acked[4];
    bit exp_err4;
    bit drained;
    int scnt, sd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input int ch, input bit err);
        exp_t e;
        e.ch  = ch;
        e.err = err;
        exp_q.push_back(e);
    endtask

    // Runs while a strobe is high; mem_done is raised in strobe cycle d. Returns strobe length.
    task automatic serve(input int d, output int len);
        len = 0;
        while ((mem_write || mem_read) && len < 300) begin
            done = (len == d);
            len++;
            tick();
        end
        done = 1'b0;
    endtask

    // Scoreboard monitor for the 2-channel instance
    always @(negedge clk) begin
        if (!rst) begin
            check("inv2", {31'd0, $onehot0(din_ack) && $onehot0(dout_valid) && !(mem_write && mem_read)}, 1);
            if (|din_ack) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected", {30'd0, din_ack}, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_ch", {30'd0, din_ack}, 32'(1) << e.ch);
                    check("sb_err", {31'd0, mem_err}, {31'd0, e.err});
                end
            end
        end
    end

    // Monitor for the 4-channel sweep
    always @(negedge clk) begin
        if (sweep_on && !rst) begin
            check("inv4", {31'd0, $onehot0(din_ack4) && $onehot0(dout_valid4) && !(mem_write4 && mem_read4)}, 1);
            for (int c = 0; c < 4; c++) begin
                if (din_ack4[c]) begin
                    check("sw_pending", {31'd0, pend[c]}, 1);
                    check("sw_err", {31'd0, mem_err4}, {31'd0, exp_err4});
                    pend[c] = 1'b0;
                    acked[c]++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; dv = 0; wen = 0; dack = 0; done = 0;
        dv4 = 0; wen4 = 0; dack4 = 0; done4 = 0;
        for (int c = 0; c < 4; c++) begin issued[c] = 0; acked[c] = 0; end
        repeat (3) tick();
        check("rst_state", {23'd0, din_ack, dout_valid, mem_write, mem_read, busy, mem_err, grant_id}, 0);
        rst = 0;

        // ch0 write, mem_done in the third strobe cycle
        dv = 2'b01; wen = 2'b01; sb_push(0, 0);
        tick();
        dv = 0;
        check("wr_grant", {31'd0, grant_id}, 0);
        check("wr_strobe", {31'd0, mem_write}, 1);
        serve(2, n);
        check("wr_len", n, 3);
        check("wr_ack", {30'd0, din_ack}, 2'b01);
        check("wr_err", {31'd0, mem_err}, 0);
        tick();
        check("wr_ack_pulse", {29'd0, din_ack, busy}, 0);

        // stray mem_done in IDLE is ignored
        done = 1; tick(); done = 0;
        check("idle_done", {31'd0, busy}, 0);

        // ch1 read, dout_ack delayed 4 cycles, ch0 dout_ack noise ignored
        dv = 2'b10; wen = 2'b00; sb_push(1, 0);
        tick();
        dv = 0;
        check("rd_strobe", {31'd0, mem_read}, 1);
        serve(1, n);
        check("rd_len", n, 2);
        check("rd_dv", {30'd0, dout_valid}, 2'b10);
        k = 0; rd_seen = 0;
        while (dout_valid[1] && k < 50) begin
            if (mem_read) rd_seen = 1;
            dack = (k == 3) ? 2'b10 : 2'b01;
            k++;
            tick();
        end
        dack = 0;
        check("resp_len", k, 4);
        check("resp_mem_read", {31'd0, rd_seen}, 0);
        check("rd_ack", {30'd0, din_ack}, 2'b10);
        tick();

        // both channels request continuously: grants alternate 0,1,0,1
        dv = 2'b11; wen = 2'b11;
        for (int t = 0; t < 4; t++) begin
            sb_push(t % 2, 0);
            tick();
            check("rr_grant", {31'd0, grant_id}, t % 2);
            serve(0, n);
            if (t == 3) dv = 0;
            tick();
        end

        // write timeout: 15 strobe cycles then mem_err with din_ack
        dv = 2'b01; wen = 2'b01; sb_push(0, 1);
        tick(); dv = 0;
        serve(100, n);
        check("tmo_len", n, 15);
        check("tmo_err", {31'd0, mem_err}, 1);
        tick();
        check("tmo_err_pulse", {31'd0, mem_err}, 0);

        // mem_done on the terminal count wins
        dv = 2'b01; wen = 2'b01; sb_push(0, 0);
        tick(); dv = 0;
        serve(14, n);
        check("tmo_edge_len", n, 15);
        check("tmo_edge_err", {31'd0, mem_err}, 0);
        tick();

        // read timeout skips RESP
        dv = 2'b10; wen = 2'b00; sb_push(1, 1);
        tick(); dv = 0;
        serve(100, n);
        check("rtmo_len", n, 15);
        check("rtmo_no_resp", {30'd0, dout_valid}, 0);
        check("rtmo_ack", {30'd0, din_ack}, 2'b10);
        tick();

        // reset during READ, then simultaneous request goes to ch0
        dv = 2'b10; wen = 2'b00;
        tick(); dv = 0;
        check("rst_rd_pre", {31'd0, mem_read}, 1);
        rst = 1; tick();
        check("rst_in_read", {23'd0, din_ack, dout_valid, mem_write, mem_read, busy, mem_err, grant_id}, 0);
        rst = 0; dv = 2'b11; wen = 2'b01; sb_push(0, 0);
        tick(); dv = 0;
        check("rst_rd_grant", {31'd0, grant_id}, 0);
        serve(0, n);
        tick();

        // reset during RESP
        dv = 2'b10; wen = 2'b00;
        tick(); dv = 0;
        serve(0, n);
        check("rst_resp_pre", {30'd0, dout_valid}, 2'b10);
        rst = 1; tick();
        check("rst_in_resp", {23'd0, din_ack, dout_valid, mem_write, mem_read, busy, mem_err, grant_id}, 0);
        rst = 0; dv = 2'b11; wen = 2'b11; sb_push(0, 0);
        tick(); dv = 0;
        check("rst_resp_grant", {31'd0, grant_id}, 0);
        serve(0, n);
        tick();
        check("sb_empty", exp_q.size(), 0);

        // random sweep on the 4-channel instance
        sweep_on = 1; scnt = 0; sd = 0; drained = 0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            for (int c = 0; c < 4; c++) begin
                if (din_ack4[c]) dv4[c] = 1'b0;
                else if (cyc < 3000 && !dv4[c] && !pend[c] && $urandom_range(0, 3) == 0) begin
                    dv4[c]  = 1'b1;
                    wen4[c] = 1'($urandom_range(0, 1));
                    pend[c] = 1'b1;
                    issued[c]++;
                end
            end
            if (mem_write4 || mem_read4) begin
                if (scnt == 0) begin
                    sd = $urandom_range(0, 20);
                    exp_err4 = (sd >= 7);
                end
                done4 = (scnt == sd);
                scnt++;
            end else begin
                if (scnt != 0) begin
                    check("sw_len", scnt, (sd >= 7) ? 7 : sd + 1);
                    scnt = 0;
                end
                done4 = ($urandom_range(0, 7) == 0);
            end
            dack4 = 4'($urandom);
            if (cyc >= 3000 && !busy4 && dv4 == 0 && pend == 0) begin
                drained = 1;
                break;
            end
            tick();
        end
        done4 = 0; dack4 = 0;
        check("sw_drained", {31'd0, drained}, 1);
        for (int c = 0; c < 4; c++) check("sw_count", acked[c], issued[c]);
        sweep_on = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_ctl_arb.md
MEM_CTL_ARB -- requirements
Module: mem_ctl_arb

Interface
REQ-001 Parameter N_CH, default 2, number of requester channels (2..8).
REQ-002 Parameter TIMEOUT, default 15, max cycles waiting for mem_done (1..255).
REQ-003 Parameter ID_W, default 1, grant_id width, equal to ceil(log2(N_CH)), minimum 1.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 din_valid  in  N_CH  per-channel request valid.
REQ-007 wen  in  N_CH  per-channel request type: 1 = write, 0 = read.
REQ-008 dout_ack  in  N_CH  per-channel read-data accept.
REQ-009 mem_done  in  1  memory access complete.
REQ-010 din_ack  out  N_CH  per-channel request acknowledge, one-cycle pulse.
REQ-011 dout_valid  out  N_CH  per-channel read data valid.
REQ-012 mem_write  out  1  memory write strobe.
REQ-013 mem_read  out  1  memory read strobe.
REQ-014 grant_id  out  ID_W  index of the currently granted channel.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 mem_err  out  1  timeout flag, one-cycle pulse.

Function
REQ-017 FSM states SHALL be IDLE, WRITE, READ, RESP and DACK; all outputs SHALL be registered or Moore-decoded from state, with no input-to-output combinational path.
REQ-018 IDLE: when any din_valid bit is high, pick the winner round-robin, latch grant_id and wen[winner], and enter WRITE or READ on the next edge.
REQ-019 Round-robin: search starts at (last_grant+1) mod N_CH; after reset last_grant = N_CH-1, so channel 0 has top priority.
REQ-020 WRITE: mem_write=1 continuously; on mem_done=1 go to DACK.
REQ-021 READ: mem_read=1 continuously; on mem_done=1 go to RESP.
REQ-022 RESP: dout_valid[grant_id]=1 held until dout_ack[grant_id]=1, then go to DACK; dout_ack on other channels is ignored.
REQ-023 DACK: din_ack[grant_id]=1 for exactly one cycle, then return to IDLE; a new arbitration cannot occur before the following cycle.
REQ-024 Latency: din_valid sampled at edge k gives mem_write or mem_read high from cycle k+1; mem_done at edge m gives din_ack (write) or dout_valid (read) high in cycle m+1.
REQ-025 Timeout counter (8 bits) clears on entry to WRITE/READ and increments each cycle there; at count == TIMEOUT-1 with mem_done=0, go to DACK with mem_err=1, coincident with that din_ack; a read timeout skips RESP.
REQ-026 mem_done arriving in the same cycle as the timeout terminal count SHALL win; no mem_err is raised.
REQ-027 mem_done in IDLE, RESP or DACK SHALL be ignored.
REQ-028 Deassertion of din_valid or a change of wen on the granted channel mid-transaction SHALL be ignored; the transaction completes.
REQ-029 Requesters SHALL drop din_valid the cycle after din_ack; if din_valid is still high in IDLE, that is a new request.
REQ-030 At most one bit of din_ack and of dout_valid SHALL be high at any time; mem_write and mem_read SHALL never be high together.

Reset
REQ-031 rst=1 at an edge SHALL force IDLE and clear din_ack, dout_valid, mem_write, mem_read, busy, mem_err, grant_id and the timeout counter, with last_grant = N_CH-1; this holds in any state, including mid-access.
REQ-032 The first arbitration SHALL occur at the first edge with rst=0 and any din_valid high.

Verification
REQ-033 N_CH=2: ch0 write, mem_done 3 cycles after mem_write rises -> mem_write high 3 cycles, din_ack[0] one pulse next cycle, grant_id=0, mem_err=0.
REQ-034 ch1 read, mem_done, dout_ack delayed 4 cycles -> dout_valid[1] high 4 cycles, then din_ack[1] pulse, mem_read low throughout RESP.
REQ-035 ch0 and ch1 both request continuously for 4 transactions -> grant order 0,1,0,1.
REQ-036 TIMEOUT=15, no mem_done -> mem_write high exactly 15 cycles, then din_ack pulse with mem_err=1; mem_done at cycle 15 instead -> mem_err=0.
REQ-037 rst asserted in READ and in RESP -> next cycle all outputs 0, busy=0; after release, ch0 wins a simultaneous request.
REQ-038 Sweep N_CH=4 with random requests, mem_done delays 0..20 and TIMEOUT=7 -> REQ-030 invariants hold and every request is acked exactly once.
